sd_init_sequencer: RTL

Sequences the SD card identification flow (CMD0, CMD8, CMD55/ACMD41 polling, CMD2, CMD3) over a single-command CMD-line engine. It sits between the top-level enable and the SD command engine, which serialises commands at SDCLK and returns parsed responses. It owns the decision of which command to issue next, retries, timeouts and error classification. On success it reports the card's RCA, OCR and capacity class and requests the fast SDCLK.

---
 rtl/sd_init_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/sd_init_sequencer.sv
// SD card identification sequencer: drives CMD0, CMD8, CMD55/ACMD41 polling,
// CMD2 and CMD3 through a single-command engine. It reports the card's RCA, OCR
// and capacity class, and requests the fast SDCLK when identification succeeds.
//
// Handshake: a command transfers on a clk_i edge where cmd_valid_o and
// cmd_ready_i are both high. cmd_valid_o and the command fields stay constant
// until that edge, and cmd_valid_o is low in the cycle after it. Only one
// command is outstanding at a time. The response is taken from the first
// rsp_done_i or rsp_timeout_i pulse that arrives in the WAIT phase.
module sd_init_sequencer #(
    parameter int RETRY_MAX   = 1000,
    parameter int WAIT_CYCLES = 1024
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    output logic         cmd_valid_o,
    input  logic         cmd_ready_i,
    output logic [5:0]   cmd_index_o,
    output logic [31:0]  cmd_arg_o,
    output logic [1:0]   cmd_rtype_o,
    input  logic         rsp_done_i,
    input  logic         rsp_timeout_i,
    input  logic         rsp_crc_err_i,
    input  logic [127:0] rsp_data_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [2:0]   err_code_o,
    output logic         v2_o,
    output logic         hcs_o,
    output logic [31:0]  ocr_o,
    output logic [15:0]  rca_o,
    output logic         fast_clk_o,
    output logic [3:0]   dbg_state_o,
    output logic [1:0]   dbg_phase_o
);

    localparam int RW = $clog2(RETRY_MAX + 1);
    localparam int GW = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD0, S_CMD8, S_ACMD55, S_ACMD41, S_GAP, S_CMD2, S_CMD3, S_DONE, S_ERROR
    } state_t;

    // DECODE is the single idle cycle between a response and the next command.
    typedef enum logic [1:0] {PH_ISSUE, PH_WAIT, PH_DECODE} phase_t;

    state_t        state_q, state_n;
    phase_t        phase_q, phase_n;
    logic [GW-1:0] gap_q, gap_n;
    logic [RW-1:0] retry_q, retry_n;
    logic          v2_n, hcs_n;
    logic [31:0]   ocr_n;
    logic [15:0]   rca_n;
    logic [2:0]    code_n;
    logic          is_cmd;
    logic          unused_data;

    // Only the low 32 bits carry R48 fields; CID/CSD bodies are not kept here.
    assign unused_data = ^rsp_data_i[127:32];

    assign is_cmd      = (state_q == S_CMD0) || (state_q == S_CMD8) || (state_q == S_ACMD55) ||
                         (state_q == S_ACMD41) || (state_q == S_CMD2) || (state_q == S_CMD3);
    assign cmd_valid_o = is_cmd && (phase_q == PH_ISSUE);
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    assign done_o      = (state_q == S_DONE);
    assign fast_clk_o  = (state_q == S_DONE);
    assign err_o       = (state_q == S_ERROR);
    assign dbg_state_o = state_q;
    assign dbg_phase_o = phase_q;

    // Register the state, phase, counters and all card information.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            phase_q    <= PH_ISSUE;
            gap_q      <= '0;
            retry_q    <= '0;
            v2_o       <= 1'b0;
            hcs_o      <= 1'b0;
            ocr_o      <= '0;
            rca_o      <= '0;
            err_code_o <= '0;
        end else begin
            state_q    <= state_n;
            phase_q    <= phase_n;
            gap_q      <= gap_n;
            retry_q    <= retry_n;
            v2_o       <= v2_n;
            hcs_o      <= hcs_n;
            ocr_o      <= ocr_n;
            rca_o      <= rca_n;
            err_code_o <= code_n;
        end
    end

    // Drive the command fields for the current command state.
    always_comb begin
        cmd_index_o = '0;
        cmd_arg_o   = '0;
        cmd_rtype_o = 2'd0;
        case (state_q)
            S_CMD8:   begin cmd_index_o = 6'd8;  cmd_arg_o = 32'h0000_01AA; cmd_rtype_o = 2'd1; end
            S_ACMD55: begin cmd_index_o = 6'd55; cmd_rtype_o = 2'd1; end
            S_ACMD41: begin
                cmd_index_o = 6'd41;
                cmd_arg_o   = v2_o ? 32'h40FF_8000 : 32'h00FF_8000;
                cmd_rtype_o = 2'd2;
            end
            S_CMD2:   begin cmd_index_o = 6'd2;  cmd_rtype_o = 2'd3; end
            S_CMD3:   begin cmd_index_o = 6'd3;  cmd_rtype_o = 2'd1; end
            default:  ;
        endcase
    end

    // Next-state logic: handshake, response classification, retries and gap timing.
    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        gap_n   = gap_q;
        retry_n = retry_q;
        v2_n    = v2_o;
        hcs_n   = hcs_o;
        ocr_n   = ocr_o;
        rca_n   = rca_o;
        code_n  = err_code_o;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (en_i) begin
                    state_n = S_CMD0;
                    phase_n = PH_ISSUE;
                    gap_n   = '0;
                    retry_n = '0;
                    v2_n    = 1'b0;
                    hcs_n   = 1'b0;
                    ocr_n   = '0;
                    rca_n   = '0;
                    code_n  = '0;
                end
            end
            S_GAP: begin
                if (gap_q == GW'(WAIT_CYCLES - 1)) begin
                    state_n = S_ACMD55;
                    phase_n = PH_ISSUE;
                    gap_n   = '0;
                end else begin
                    gap_n = gap_q + GW'(1);
                end
            end
            default: begin
                case (phase_q)
                    PH_ISSUE:  if (cmd_ready_i) phase_n = PH_WAIT;
                    PH_DECODE: phase_n = PH_ISSUE;
                    default: begin
                        if (rsp_timeout_i) begin
                            // A card that ignores CMD8 is a v1 card, not an error.
                            if (state_q == S_CMD8) begin
                                v2_n    = 1'b0;
                                state_n = S_ACMD55;
                                phase_n = PH_DECODE;
                            end else begin
                                state_n = S_ERROR;
                                phase_n = PH_ISSUE;
                                code_n  = 3'd2;
                            end
                        end else if (rsp_done_i) begin
                            phase_n = PH_DECODE;
                            if (rsp_crc_err_i && ((cmd_rtype_o == 2'd1) || (cmd_rtype_o == 2'd3))) begin
                                state_n = S_ERROR;
                                phase_n = PH_ISSUE;
                                code_n  = 3'd3;
                            end else begin
                                case (state_q)
                                    S_CMD0:   state_n = S_CMD8;
                                    S_CMD8: begin
                                        if (rsp_data_i[11:0] == 12'h1AA) begin
                                            v2_n    = 1'b1;
                                            state_n = S_ACMD55;
                                        end else begin
                                            state_n = S_ERROR;
                                            phase_n = PH_ISSUE;
                                            code_n  = 3'd1;
                                        end
                                    end
                                    S_ACMD55: state_n = S_ACMD41;
                                    S_ACMD41: begin
                                        ocr_n = rsp_data_i[31:0];
                                        if (rsp_data_i[31]) begin
                                            hcs_n   = v2_o & rsp_data_i[30];
                                            state_n = S_CMD2;
                                        end else begin
                                            retry_n = retry_q + RW'(1);
                                            phase_n = PH_ISSUE;
                                            if (retry_q == RW'(RETRY_MAX - 1)) begin
                                                state_n = S_ERROR;
                                                code_n  = 3'd4;
                                            end else begin
                                                state_n = S_GAP;
                                                gap_n   = '0;
                                            end
                                        end
                                    end
                                    S_CMD2:   state_n = S_CMD3;
                                    default: begin
                                        rca_n   = rsp_data_i[31:16];
                                        state_n = S_DONE;
                                        phase_n = PH_ISSUE;
                                    end
                                endcase
                            end
                        end
                    end
                endcase
            end
        endcase
    end

endmodule
